// File: rtl/adv_scan_pkg.sv
// adv_scan_pkg: shared definitions for the BLE advertising-channel scanner.
//   - state_t   : scanner FSM states
//   - CH37..39  : BLE advertising channel indices
//   - next_chan : next enabled channel after 'cur' in hop order 37->38->39->37
package adv_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUNE   = 2'd1,
        SETTLE = 2'd2,
        LISTEN = 2'd3
    } state_t;

    localparam logic [5:0] CH37 = 6'd37;
    localparam logic [5:0] CH38 = 6'd38;
    localparam logic [5:0] CH39 = 6'd39;

    // Searches forward from the channel after 'cur' and wraps back to 'cur'
    // itself, so a single-channel mask re-selects the same channel. Calling
    // it with cur=CH39 therefore yields the lowest enabled channel.
    function automatic logic [5:0] next_chan(input logic [5:0] cur, input logic [2:0] mask);
        logic [5:0] res;
        res = cur;
        case (cur)
            CH37: begin
                if (mask[1]) res = CH38;
                else if (mask[2]) res = CH39;
                else if (mask[0]) res = CH37;
                else res = cur;
            end
            CH38: begin
                if (mask[2]) res = CH39;
                else if (mask[0]) res = CH37;
                else if (mask[1]) res = CH38;
                else res = cur;
            end
            default: begin
                if (mask[0]) res = CH37;
                else if (mask[1]) res = CH38;
                else if (mask[2]) res = CH39;
                else res = cur;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/adv_scan_controller_if.sv
// adv_scan_controller_if: control/status bundle between the board top level,
// the LO tuner and the packet sniffer on one side and the scanner on the other.
//   slave  : scanner side (takes scan_en/chan_mask/tune_ack/packet_detected,
//            drives sniffer_en/channel/tune_req/pkt_led/pkt_count/last_chan/
//            tune_err/busy)
//   master : environment side (the opposite directions)
interface adv_scan_controller_if #(
    parameter int CNT_W = 16
);
    import adv_scan_pkg::*;

    logic             scan_en;
    logic [2:0]       chan_mask;
    logic             tune_ack;
    logic             packet_detected;
    logic             sniffer_en;
    logic [5:0]       channel;
    logic             tune_req;
    logic             pkt_led;
    logic [CNT_W-1:0] pkt_count;
    logic [5:0]       last_chan;
    logic             tune_err;
    logic             busy;

    modport slave (
        input  scan_en, chan_mask, tune_ack, packet_detected,
        output sniffer_en, channel, tune_req, pkt_led, pkt_count, last_chan, tune_err, busy
    );

    modport master (
        output scan_en, chan_mask, tune_ack, packet_detected,
        input  sniffer_en, channel, tune_req, pkt_led, pkt_count, last_chan, tune_err, busy
    );

endinterface

// File: rtl/adv_hold_timer.sv
// adv_hold_timer: loadable, retriggerable down-counter.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val this edge (wins over counting)
//   load_val  : value to load
//   count     : current count, stops at zero
//   active    : set by a load, stays high through count==0 and drops the
//               following cycle, so a load of N-1 yields exactly N high cycles
module adv_hold_timer
    import adv_scan_pkg::*;
#(
    parameter int W = 29
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         active
);

    // Down-counter with load priority and an active flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= {W{1'b0}};
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (count != {W{1'b0}}) begin
            count  <= count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            active <= 1'b0;
        end
    end

endmodule

// File: rtl/adv_scan_controller.sv
// adv_scan_controller: sequences the BLE receive chain over advertising
// channels 37/38/39 (tune -> settle -> listen -> hop), counts detected
// packets and stretches a packet indicator for the board LED.
//   clk, rst : 16 MHz clock, asynchronous active-low reset
//   bus      : adv_scan_controller_if.slave (scan_en, chan_mask, tune_ack,
//              packet_detected in; sniffer_en, channel, tune_req, pkt_led,
//              pkt_count, last_chan, tune_err, busy out; all outputs registered)
// Build option: define ADV_STAY_ON_HIT_EN to reload the dwell timer on every
// counted detection, keeping the scanner on an active channel.
module adv_scan_controller
    import adv_scan_pkg::*;
#(
    parameter int DWELL_CYCLES   = 16_000_000,
    parameter int SETTLE_CYCLES  = 1_600,
    parameter int TUNE_TO_CYCLES = 16_000,
    parameter int HOLD_CYCLES    = 32_000_000,
    parameter int TIMER_W        = 29,
    parameter int CNT_W          = 16
) (
    input logic                  clk,
    input logic                  rst,
    adv_scan_controller_if.slave bus
);

    localparam logic [TIMER_W-1:0] DWELL_LD   = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TUNE_TO_LD = TIMER_W'(TUNE_TO_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LD    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               tmr_load_s;
    logic [TIMER_W-1:0] tmr_val_s;
    logic [TIMER_W-1:0] tmr_count_s;
    logic               tmr_active_s;
    logic               tmr_zero_s;
    logic               chan_load_s;
    logic [5:0]         chan_nxt_s;
    logic               set_err_s;
    logic               run_s;
    logic               hit_s;
    logic               led_active_s;
    logic [TIMER_W-1:0] led_count_s;
    logic               unused_ok_s;

    logic               sniffer_en_r;
    logic [5:0]         channel_r;
    logic               tune_req_r;
    logic [CNT_W-1:0]   pkt_count_r;
    logic [5:0]         last_chan_r;
    logic               tune_err_r;
    logic               busy_r;

    assign run_s       = bus.scan_en && (bus.chan_mask != 3'b000);
    assign tmr_zero_s  = (tmr_count_s == {TIMER_W{1'b0}});
    assign hit_s       = bus.packet_detected && (state_r == LISTEN);
    assign unused_ok_s = &{1'b0, tmr_active_s, led_count_s};

    adv_hold_timer #(.W(TIMER_W)) u_state_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .count    (tmr_count_s),
        .active   (tmr_active_s)
    );

    adv_hold_timer #(.W(TIMER_W)) u_led_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (hit_s),
        .load_val (HOLD_LD),
        .count    (led_count_s),
        .active   (led_active_s)
    );

    // Next-state, timer load and channel selection.
    always_comb begin
        state_nxt_s = state_r;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {TIMER_W{1'b0}};
        set_err_s   = 1'b0;
        chan_load_s = 1'b0;
        chan_nxt_s  = channel_r;
        if (!run_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = TUNE;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TUNE_TO_LD;
                    chan_load_s = 1'b1;
                    chan_nxt_s  = next_chan(CH39, bus.chan_mask);
                end
                TUNE: begin
                    if (bus.tune_ack) begin
                        state_nxt_s = SETTLE;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = SETTLE_LD;
                    end else if (tmr_zero_s) begin
                        // Timed out: flag it but keep scanning on this channel.
                        set_err_s   = 1'b1;
                        state_nxt_s = SETTLE;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = SETTLE_LD;
                    end else begin
                        state_nxt_s = TUNE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero_s) begin
                        state_nxt_s = LISTEN;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = DWELL_LD;
                    end else begin
                        state_nxt_s = SETTLE;
                    end
                end
                LISTEN: begin
`ifdef ADV_STAY_ON_HIT_EN
                    // A hit restarts the dwell and overrides a coincident expiry.
                    if (hit_s) begin
                        state_nxt_s = LISTEN;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = DWELL_LD;
                    end else if (tmr_zero_s) begin
                        state_nxt_s = TUNE;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = TUNE_TO_LD;
                        chan_load_s = 1'b1;
                        chan_nxt_s  = next_chan(channel_r, bus.chan_mask);
                    end else begin
                        state_nxt_s = LISTEN;
                    end
`else
                    if (tmr_zero_s) begin
                        state_nxt_s = TUNE;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = TUNE_TO_LD;
                        chan_load_s = 1'b1;
                        chan_nxt_s  = next_chan(channel_r, bus.chan_mask);
                    end else begin
                        state_nxt_s = LISTEN;
                    end
`endif
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register and registered outputs; strobes follow the next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            sniffer_en_r <= 1'b0;
            tune_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            channel_r    <= CH37;
            tune_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sniffer_en_r <= (state_nxt_s == LISTEN);
            tune_req_r   <= (state_nxt_s == TUNE);
            busy_r       <= (state_nxt_s != IDLE);
            channel_r    <= chan_load_s ? chan_nxt_s : channel_r;
            tune_err_r   <= tune_err_r | set_err_s;
        end
    end

    // Saturating packet counter and channel of the latest detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_r <= {CNT_W{1'b0}};
            last_chan_r <= 6'd0;
        end else if (hit_s) begin
            pkt_count_r <= (pkt_count_r == CNT_MAX) ? pkt_count_r
                                                     : pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            last_chan_r <= channel_r;
        end else begin
            pkt_count_r <= pkt_count_r;
            last_chan_r <= last_chan_r;
        end
    end

    assign bus.sniffer_en = sniffer_en_r;
    assign bus.channel    = channel_r;
    assign bus.tune_req   = tune_req_r;
    assign bus.pkt_led    = led_active_s;
    assign bus.pkt_count  = pkt_count_r;
    assign bus.last_chan  = last_chan_r;
    assign bus.tune_err   = tune_err_r;
    assign bus.busy       = busy_r;

endmodule
